i2c_slave_regfile: RTL and testbench

//  I2C target (slave) that is the far end of i2c_master: 7-bit address match, offset byte, burst write/read into an internal byte register file.

---
 rtl/i2c_slave_regfile.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target with 7-bit address match, offset pointer and burst read/write into a byte register file.
// Define I2C_SLV_GCALL_EN to also acknowledge the general-call write address (0x00).
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR   = 7'h50,
    parameter int         REG_NUM      = 16,
    parameter int         FILTER_LEN   = 3,
    parameter int         SDA_HOLD_CYC = 8
) (
    input  logic                       SYSTEM_CLK,
    input  logic                       RESET,
    input  logic                       iSCL,
    input  logic                       iSDA,
    output logic                       oSDAOE,
    output logic [REG_NUM*8-1:0]       regs_flat,
    output logic                       wr_pulse,
    output logic [$clog2(REG_NUM)-1:0] wr_index,
    output logic [7:0]                 wr_byte,
    output logic                       busy,
    output logic [3:0]                 state_s
);
    localparam int PW = $clog2(REG_NUM);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int HW = (SDA_HOLD_CYC > 1) ? $clog2(SDA_HOLD_CYC) : 1;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ADDR       = 4'd1,
        ST_ADDR_ACK   = 4'd2,
        ST_OFFSET     = 4'd3,
        ST_OFFSET_ACK = 4'd4,
        ST_WR_DATA    = 4'd5,
        ST_WR_ACK     = 4'd6,
        ST_RD_DATA    = 4'd7,
        ST_RD_ACK     = 4'd8,
        ST_IGNORE     = 4'd9
    } state_t;

    state_t               state_r, state_nx_s;
    logic [1:0]           sync1_r, sync2_r, filt_r, filt_d_r;
    logic [1:0][FW-1:0]   fcnt_r;
    logic [3:0]           bit_cnt_r;
    logic [7:0]           shift_r, rd_byte_r;
    logic                 rw_r;
    logic [PW-1:0]        ptr_r;
    logic                 hold_act_r, pend_sda_r, pend_wr_r;
    logic [HW-1:0]        hold_cnt_r;
    logic [7:0]           regs_r [REG_NUM];

    logic scl_f_s, sda_f_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    logic last_bit_s, addr_hit_s, drive_val_s, rd_load_s;
    logic [7:0] byte_in_s, reg_at_ptr_s;

    assign scl_f_s      = filt_r[0];
    assign sda_f_s      = filt_r[1];
    assign scl_rise_s   = scl_f_s & ~filt_d_r[0];
    assign scl_fall_s   = ~scl_f_s & filt_d_r[0];
    // START/STOP need SCL high both before and after the SDA edge
    assign start_s      = scl_f_s & filt_d_r[0] & ~sda_f_s & filt_d_r[1];
    assign stop_s       = scl_f_s & filt_d_r[0] & sda_f_s & ~filt_d_r[1];
    assign byte_in_s    = {shift_r[6:0], sda_f_s};
    assign last_bit_s   = (bit_cnt_r == 4'd7);
    assign reg_at_ptr_s = regs_r[ptr_r];
    assign state_s      = state_r;

`ifdef I2C_SLV_GCALL_EN
    assign addr_hit_s = (byte_in_s[7:1] == SLAVE_ADDR) || (byte_in_s == 8'h00);
`else
    assign addr_hit_s = (byte_in_s[7:1] == SLAVE_ADDR);
`endif

    for (genvar k = 0; k < REG_NUM; k++) begin : g_flat
        assign regs_flat[8*k +: 8] = regs_r[k];
    end

    // Two-stage synchronizer and stability filter for SCL (bit 0) and SDA (bit 1)
    always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
        if (RESET) begin
            sync1_r  <= 2'b11;
            sync2_r  <= 2'b11;
            filt_r   <= 2'b11;
            filt_d_r <= 2'b11;
            fcnt_r   <= {2*FW{1'b0}};
        end else begin
            sync1_r  <= {iSDA, iSCL};
            sync2_r  <= sync1_r;
            filt_d_r <= filt_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= {FW{1'b0}};
                end else if (fcnt_r[i] == FW'(FILTER_LEN - 1)) begin
                    filt_r[i] <= sync2_r[i];
                    fcnt_r[i] <= {FW{1'b0}};
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + FW'(1);
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state: START/STOP win, otherwise advance on accepted SCL rise
    always_comb begin
        state_nx_s = state_r;
        if (start_s) begin
            state_nx_s = ST_ADDR;
        end else if (stop_s) begin
            state_nx_s = ST_IDLE;
        end else if (scl_rise_s) begin
            case (state_r)
                ST_ADDR:       state_nx_s = last_bit_s ? (addr_hit_s ? ST_ADDR_ACK : ST_IGNORE) : ST_ADDR;
                ST_ADDR_ACK:   state_nx_s = rw_r ? ST_RD_DATA : ST_OFFSET;
                ST_OFFSET:     state_nx_s = last_bit_s ? ST_OFFSET_ACK : ST_OFFSET;
                ST_OFFSET_ACK: state_nx_s = ST_WR_DATA;
                ST_WR_DATA:    state_nx_s = last_bit_s ? ST_WR_ACK : ST_WR_DATA;
                ST_WR_ACK:     state_nx_s = ST_WR_DATA;
                ST_RD_DATA:    state_nx_s = last_bit_s ? ST_RD_ACK : ST_RD_DATA;
                ST_RD_ACK:     state_nx_s = sda_f_s ? ST_IGNORE : ST_RD_DATA;
                ST_IDLE:       state_nx_s = ST_IDLE;
                ST_IGNORE:     state_nx_s = ST_IGNORE;
                default:       state_nx_s = ST_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // FSM outputs: SDA level to present in the slot that begins at this SCL fall
    always_comb begin
        drive_val_s = 1'b1;
        rd_load_s   = 1'b0;
        case (state_r)
            ST_ADDR_ACK, ST_OFFSET_ACK, ST_WR_ACK: drive_val_s = 1'b0;
            ST_RD_DATA: begin
                if (bit_cnt_r == 4'd0) begin
                    rd_load_s   = 1'b1;
                    drive_val_s = reg_at_ptr_s[7];
                end else begin
                    drive_val_s = rd_byte_r[3'd7 - bit_cnt_r[2:0]];
                end
            end
            default: drive_val_s = 1'b1;
        endcase
    end

    // Bit counter, shifter, pointer, SDA hold timer and register-file writes
    always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
        if (RESET) begin
            oSDAOE     <= 1'b1;
            busy       <= 1'b0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            rd_byte_r  <= 8'h00;
            rw_r       <= 1'b0;
            ptr_r      <= {PW{1'b0}};
            hold_act_r <= 1'b0;
            hold_cnt_r <= {HW{1'b0}};
            pend_sda_r <= 1'b1;
            pend_wr_r  <= 1'b0;
            wr_pulse   <= 1'b0;
            wr_index   <= {PW{1'b0}};
            wr_byte    <= 8'h00;
            for (int k = 0; k < REG_NUM; k++) begin
                regs_r[k] <= 8'h00;
            end
        end else begin
            wr_pulse <= 1'b0;
            if (start_s || stop_s) begin
                busy       <= start_s;
                bit_cnt_r  <= 4'd0;
                oSDAOE     <= 1'b1;
                hold_act_r <= 1'b0;
                pend_wr_r  <= 1'b0;
            end else if (scl_rise_s) begin
                case (state_r)
                    ST_ADDR, ST_OFFSET, ST_WR_DATA: begin
                        shift_r <= byte_in_s;
                        if (last_bit_s) begin
                            bit_cnt_r <= 4'd8;
                            if (state_r == ST_ADDR) rw_r <= byte_in_s[0];
                            if (state_r == ST_OFFSET) ptr_r <= byte_in_s[PW-1:0];
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                    ST_RD_DATA: begin
                        if (last_bit_s) begin
                            bit_cnt_r <= 4'd8;
                            ptr_r     <= ptr_r + PW'(1);
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                    ST_ADDR_ACK, ST_OFFSET_ACK, ST_WR_ACK, ST_RD_ACK: bit_cnt_r <= 4'd0;
                    default: bit_cnt_r <= bit_cnt_r;
                endcase
            end else if (scl_fall_s) begin
                hold_act_r <= 1'b1;
                hold_cnt_r <= {HW{1'b0}};
                pend_sda_r <= drive_val_s;
                pend_wr_r  <= (state_r == ST_WR_ACK);
                if (rd_load_s) rd_byte_r <= reg_at_ptr_s;
            end else if (hold_act_r) begin
                if (hold_cnt_r == HW'(SDA_HOLD_CYC - 1)) begin
                    hold_act_r <= 1'b0;
                    oSDAOE     <= pend_sda_r;
                    pend_wr_r  <= 1'b0;
                    // The byte commits at the moment the ACK is actually driven
                    if (pend_wr_r) begin
                        regs_r[ptr_r] <= shift_r;
                        wr_pulse      <= 1'b1;
                        wr_index      <= ptr_r;
                        wr_byte       <= shift_r;
                        ptr_r         <= ptr_r + PW'(1);
                    end
                end else begin
                    hold_cnt_r <= hold_cnt_r + HW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bus-master bench for i2c_slave_regfile: directed scenarios plus random transactions against an array model.
module tb_i2c_slave_regfile;
    localparam int Q  = 10;
    localparam int RN = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_line, oe, wr_pulse, busy;
    logic [RN*8-1:0] regs_flat;
    logic [3:0] wr_index, state_s;
    logic [7:0] wr_byte;

    assign sda_line = m_sda & oe;

    i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .REG_NUM(RN), .FILTER_LEN(3), .SDA_HOLD_CYC(8)) dut (
        .SYSTEM_CLK(clk), .RESET(rst), .iSCL(m_scl), .iSDA(sda_line), .oSDAOE(oe),
        .regs_flat(regs_flat), .wr_pulse(wr_pulse), .wr_index(wr_index), .wr_byte(wr_byte),
        .busy(busy), .state_s(state_s));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int low_cnt = 0;
    int wr_seen = 0;
    int mptr = 0;
    logic [7:0]  mregs [RN];
    logic [7:0]  tx [4];
    logic [11:0] obs_wr_q [$];
    logic [11:0] exp_wr_q [$];

    always @(negedge clk) begin
        if (wr_pulse) obs_wr_q.push_back({wr_index, wr_byte});
        if (!oe) low_cnt++;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int k = 0; k < RN; k++) f[8*k +: 8] = mregs[k];
        return f;
    endfunction

    function automatic logic addr_match(input logic [7:0] a);
`ifdef I2C_SLV_GCALL_EN
        return (a[7:1] == 7'h50) || (a == 8'h00);
`else
        return (a[7:1] == 7'h50);
`endif
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic drv, output logic smp);
        m_sda = drv; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        smp = sda_line; wait_cyc(Q);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic start_cond();
        m_sda = 1'b1; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        m_sda = 1'b0; wait_cyc(Q);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        m_sda = 1'b1; wait_cyc(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, d);
            b[i] = d;
        end
        bit_xfer(nack, d);
    endtask

    task automatic end_checks();
        check_eq("state_idle", state_s, 4'd0);
        check_eq("busy_idle", busy, 1'b0);
        check_eq("regs_flat", regs_flat, model_flat());
        check_eq("wr_count", obs_wr_q.size(), exp_wr_q.size());
        for (int i = wr_seen; i < exp_wr_q.size(); i++) begin
            if (i < obs_wr_q.size()) check_eq("wr_event", obs_wr_q[i], exp_wr_q[i]);
        end
        wr_seen = exp_wr_q.size();
    endtask

    task automatic wr_txn(input logic [7:0] a, input logic [7:0] off, input int n);
        logic ack, hit;
        int low0;
        hit = addr_match(a);
        low0 = low_cnt;
        start_cond();
        check_eq("busy_start", busy, 1'b1);
        write_byte(a, ack);
        check_eq("addr_ack", ack, !hit);
        write_byte(off, ack);
        check_eq("off_ack", ack, !hit);
        if (hit) mptr = int'(off) % RN;
        for (int i = 0; i < n; i++) begin
            write_byte(tx[i], ack);
            check_eq("data_ack", ack, !hit);
            if (hit) begin
                mregs[mptr] = tx[i];
                exp_wr_q.push_back({4'(mptr), tx[i]});
                mptr = (mptr + 1) % RN;
            end
        end
        stop_cond();
        if (!hit) check_eq("no_drive", low_cnt - low0, 0);
        end_checks();
    endtask

    task automatic rd_txn(input logic set_off, input logic [7:0] off, input int n);
        logic ack;
        logic [7:0] b;
        start_cond();
        check_eq("busy_start", busy, 1'b1);
        if (set_off) begin
            write_byte(8'hA0, ack);
            check_eq("rd_waddr_ack", ack, 1'b0);
            write_byte(off, ack);
            check_eq("rd_off_ack", ack, 1'b0);
            mptr = int'(off) % RN;
            start_cond();
        end
        write_byte(8'hA1, ack);
        check_eq("raddr_ack", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            check_eq("rd_data", b, mregs[mptr]);
            mptr = (mptr + 1) % RN;
        end
        check_eq("rel_after_nack", oe, 1'b1);
        stop_cond();
        end_checks();
    endtask

    initial begin
        logic ack;
        logic [7:0] a;
        int kind, n;
        for (int k = 0; k < RN; k++) mregs[k] = 8'h00;
        wait_cyc(5);
        check_eq("rst_oe", oe, 1'b1);
        check_eq("rst_regs", regs_flat, 128'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_state", state_s, 4'd0);
        check_eq("rst_wr", {wr_pulse, wr_index, wr_byte}, 13'h0);
        rst = 1'b0;
        wait_cyc(10);

        // Burst write, offset-then-Sr read, wrap-around
        tx[0] = 8'h11; tx[1] = 8'h22;
        wr_txn(8'hA0, 8'h03, 2);
        rd_txn(1'b1, 8'h03, 2);
        tx[0] = 8'hAA; tx[1] = 8'hBB;
        wr_txn(8'hA0, 8'h0F, 2);
        rd_txn(1'b1, 8'h0F, 2);

        // Address mismatch and general-call address
        wr_txn(8'hA2, 8'h05, 0);
        tx[0] = 8'h5A;
        wr_txn(8'h00, 8'h02, 1);

        // Glitch on SCL during a write
        start_cond();
        write_byte(8'hA0, ack); check_eq("gl_addr_ack", ack, 1'b0);
        write_byte(8'h08, ack); check_eq("gl_off_ack", ack, 1'b0);
        mptr = 8;
        m_scl = 1'b1; wait_cyc(1); m_scl = 1'b0; wait_cyc(Q);
        write_byte(8'h3C, ack); check_eq("gl_data_ack", ack, 1'b0);
        mregs[8] = 8'h3C; exp_wr_q.push_back({4'd8, 8'h3C}); mptr = 9;
        stop_cond();
        end_checks();

        // STOP after four data bits: no write, pointer stays at the offset
        tx[0] = 8'h77;
        wr_txn(8'hA0, 8'h09, 1);
        start_cond();
        write_byte(8'hA0, ack); check_eq("ab_addr_ack", ack, 1'b0);
        write_byte(8'h09, ack); check_eq("ab_off_ack", ack, 1'b0);
        mptr = 9;
        for (int i = 0; i < 4; i++) bit_xfer(i[0], ack);
        stop_cond();
        end_checks();
        rd_txn(1'b0, 8'h00, 1);

        // Reset in the middle of a read while SDA is driven low
        tx[0] = 8'h0F;
        wr_txn(8'hA0, 8'h06, 1);
        start_cond();
        write_byte(8'hA0, ack);
        write_byte(8'h06, ack);
        start_cond();
        write_byte(8'hA1, ack);
        check_eq("mid_rd_ack", ack, 1'b0);
        wait_cyc(Q);
        check_eq("mid_rd_drive", oe, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_oe", oe, 1'b1);
        check_eq("mid_rst_regs", regs_flat, 128'h0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_state", state_s, 4'd0);
        wait_cyc(3);
        rst = 1'b0;
        for (int k = 0; k < RN; k++) mregs[k] = 8'h00;
        mptr = 0;
        wait_cyc(5);
        stop_cond();
        end_checks();

        // Random transactions
        for (int t = 0; t < 10; t++) begin
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            case (kind)
                0: begin
                    for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
                    wr_txn(8'hA0, 8'($urandom), n);
                end
                1: rd_txn(1'b1, 8'($urandom), n);
                2: rd_txn(1'b0, 8'h00, n);
                default: begin
                    do a = 8'($urandom); while (a[7:1] == 7'h50 || a == 8'h00);
                    for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
                    wr_txn(a, 8'($urandom), n);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
